// File: rtl/pcs_transmit_pkg.sv
// pcs_transmit_pkg: one-hot FSM states, special code groups and 8b/10b sub-block tables
`define TRUE 1'b1
`define FALSE 1'b0
package pcs_transmit_pkg;
  localparam logic [4:0] XMIT_IDLE_K = 5'b00001;
  localparam logic [4:0] XMIT_IDLE_D = 5'b00010;
  localparam logic [4:0] TX_PACKET = 5'b00100;
  localparam logic [4:0] EPD2 = 5'b01000;
  localparam logic [4:0] EPD3 = 5'b10000;
  typedef struct packed {
    logic k;
    logic [7:0] d;
  } cg_t;
  localparam cg_t K28_5 = {1'b1, 8'hBC};
  localparam cg_t K27_7 = {1'b1, 8'hFB};
  localparam cg_t K29_7 = {1'b1, 8'hFD};
  localparam cg_t K23_7 = {1'b1, 8'hF7};
  localparam cg_t K30_7 = {1'b1, 8'hFE};
  localparam cg_t D5_6 = {1'b0, 8'hC5};
  localparam cg_t D16_2 = {1'b0, 8'h50};
  function automatic logic [5:0] enc6(input logic [4:0] x);
    case (x)
      5'd0: enc6 = 6'b100111;
      5'd1: enc6 = 6'b011101;
      5'd2: enc6 = 6'b101101;
      5'd3: enc6 = 6'b110001;
      5'd4: enc6 = 6'b110101;
      5'd5: enc6 = 6'b101001;
      5'd6: enc6 = 6'b011001;
      5'd7: enc6 = 6'b111000;
      5'd8: enc6 = 6'b111001;
      5'd9: enc6 = 6'b100101;
      5'd10: enc6 = 6'b010101;
      5'd11: enc6 = 6'b110100;
      5'd12: enc6 = 6'b001101;
      5'd13: enc6 = 6'b101100;
      5'd14: enc6 = 6'b011100;
      5'd15: enc6 = 6'b010111;
      5'd16: enc6 = 6'b011011;
      5'd17: enc6 = 6'b100011;
      5'd18: enc6 = 6'b010011;
      5'd19: enc6 = 6'b110010;
      5'd20: enc6 = 6'b001011;
      5'd21: enc6 = 6'b101010;
      5'd22: enc6 = 6'b011010;
      5'd23: enc6 = 6'b111010;
      5'd24: enc6 = 6'b110011;
      5'd25: enc6 = 6'b100110;
      5'd26: enc6 = 6'b010110;
      5'd27: enc6 = 6'b110110;
      5'd28: enc6 = 6'b001110;
      5'd29: enc6 = 6'b101110;
      5'd30: enc6 = 6'b011110;
      default: enc6 = 6'b101011;
    endcase
  endfunction
  function automatic logic [3:0] enc4(input logic [2:0] y);
    case (y)
      3'd0: enc4 = 4'b1011;
      3'd1: enc4 = 4'b1001;
      3'd2: enc4 = 4'b0101;
      3'd3: enc4 = 4'b1100;
      3'd4: enc4 = 4'b1101;
      3'd5: enc4 = 4'b1010;
      3'd6: enc4 = 4'b0110;
      default: enc4 = 4'b1110;
    endcase
  endfunction
endpackage

// File: rtl/encoder_8b10b.sv
// encoder_8b10b: combinational 8b/10b encoder, tables hold the RD- column and RD+ is derived by complement
module encoder_8b10b
  import pcs_transmit_pkg::*;
(
  input logic [7:0] data,
  input logic is_k,
  input logic rd_in,
  output logic [9:0] code,
  output logic rd_out
);
  logic k28, n6, rd6, a7, alt;
  logic [5:0] b6, c6;
  logic [3:0] b4, c4;
  assign k28 = is_k && data[4:0] == 5'd28;
  assign b6 = k28 ? 6'b001111 : enc6(data[4:0]);
  assign n6 = $countones(b6) != 3;
  assign c6 = (rd_in && (n6 || b6 == 6'b111000)) ? ~b6 : b6;
  assign rd6 = rd_in ^ n6;
  // alternate x.7 avoids a run of five equal bits across the e/i-f boundary
  assign a7 = is_k || (!rd6 && c6[1:0] == 2'b11) || (rd6 && c6[1:0] == 2'b00);
  assign b4 = data[7:5] == 3'd7 ? (a7 ? 4'b0111 : 4'b1110) : enc4(data[7:5]);
  assign alt = $countones(b4) == 2 && data[7:5] != 3'd3;
  assign c4 = (k28 ? rd6 ^ alt : rd6 && !alt) ? ~b4 : b4;
  assign rd_out = rd6 ^ ($countones(b4) != 2);
  assign code = {c6, c4};
endmodule

// File: rtl/pcs_transmit.sv
// pcs_transmit: 1000BASE-X PCS transmit FSM feeding the 8b/10b encoder
// PCS_TX_ERR_PROP_EN: TX_ER during a packet sends /V/ instead of data
module pcs_transmit
  import pcs_transmit_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input logic Clk,
  input logic mr_main_reset_n,
  input logic [7:0] TXD,
  input logic TX_EN,
  input logic TX_ER,
  output logic [9:0] tx_code_group,
  output logic tx_even,
  output logic tx_rd_pos,
  output logic [DROP_CNT_W-1:0] dropped_octets
);
  logic [4:0] state, nxt;
  cg_t cg;
  logic drop, err, rd_nxt;
  logic [9:0] code;
`ifdef PCS_TX_ERR_PROP_EN
  assign err = TX_ER;
`else
  logic unused_er;
  assign unused_er = TX_ER;
  assign err = `FALSE;
`endif
  always_ff @(posedge Clk or negedge mr_main_reset_n)
    if (!mr_main_reset_n) begin
      state <= XMIT_IDLE_D;
      tx_code_group <= 10'h0FA;
      tx_even <= 1'b1;
      tx_rd_pos <= 1'b1;
      dropped_octets <= '0;
    end else begin
      state <= nxt;
      tx_code_group <= code;
      tx_even <= !tx_even;
      tx_rd_pos <= rd_nxt;
      if (drop && !(&dropped_octets)) dropped_octets <= dropped_octets + 1'b1;
    end
  // tx_even is the slot of the current group, so the group being built goes in slot !tx_even
  always_comb begin
    case (state)
      XMIT_IDLE_K: nxt = TX_EN ? TX_PACKET : XMIT_IDLE_D;
      XMIT_IDLE_D: nxt = XMIT_IDLE_K;
      TX_PACKET: nxt = TX_EN ? TX_PACKET : EPD2;
      EPD2: nxt = tx_even ? XMIT_IDLE_K : EPD3;
      default: nxt = XMIT_IDLE_K;
    endcase
  end
  always_comb begin
    case (state)
      XMIT_IDLE_K: cg = TX_EN ? K27_7 : K28_5;
      XMIT_IDLE_D: cg = tx_rd_pos ? D16_2 : D5_6;
      TX_PACKET: cg = !TX_EN ? K29_7 : err ? K30_7 : cg_t'({1'b0, TXD});
      default: cg = K23_7;
    endcase
    drop = TX_EN && (state == XMIT_IDLE_D || state == EPD2 || state == EPD3);
  end
  encoder_8b10b enc (
    .data(cg.d),
    .is_k(cg.k),
    .rd_in(tx_rd_pos),
    .code(code),
    .rd_out(rd_nxt)
  );
endmodule

// File: tb/tb_pcs_transmit.sv
// tb_pcs_transmit: directed vectors with hand-computed code groups for pcs_transmit
module tb_pcs_transmit;
  localparam int W = 4;
`ifdef PCS_TX_ERR_PROP_EN
  localparam logic [9:0] ER_CG = 10'h1E8;
`else
  localparam logic [9:0] ER_CG = 10'h2A5;
`endif
  logic Clk = 1'b0;
  logic mr_main_reset_n = 1'b0;
  logic [7:0] TXD = 8'h00;
  logic TX_EN = 1'b0;
  logic TX_ER = 1'b0;
  logic [9:0] tx_code_group;
  logic tx_even, tx_rd_pos;
  logic [W-1:0] dropped_octets;
  int total = 0;
  int bad = 0;
  int n = 0;
  pcs_transmit #(.DROP_CNT_W(W)) dut (
    .Clk(Clk),
    .mr_main_reset_n(mr_main_reset_n),
    .TXD(TXD),
    .TX_EN(TX_EN),
    .TX_ER(TX_ER),
    .tx_code_group(tx_code_group),
    .tx_even(tx_even),
    .tx_rd_pos(tx_rd_pos),
    .dropped_octets(dropped_octets)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h want %0h", tag, n, got, exp);
    end
  endtask
  task automatic drive(input logic en, input logic er, input logic [7:0] d);
    TX_EN = en;
    TX_ER = er;
    TXD = d;
    @(posedge Clk);
    #1;
    n++;
  endtask
  task automatic cyc(input logic en, input logic er, input logic [7:0] d,
                     input logic [9:0] c, input logic ev, input logic rd, input int dr);
    drive(en, er, d);
    check("code", tx_code_group, c);
    check("even", tx_even, ev);
    check("rd", tx_rd_pos, rd);
    check("drop", dropped_octets, dr);
  endtask
  initial begin
    #12;
    check("rst_code", tx_code_group, 10'h0FA);
    check("rst_even", tx_even, 1'b1);
    check("rst_rd", tx_rd_pos, 1'b1);
    check("rst_drop", dropped_octets, 0);
    #8 mr_main_reset_n = 1'b1;
    cyc(0, 0, 8'h00, 10'h245, 0, 0, 0);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 0);
    cyc(0, 0, 8'h00, 10'h245, 0, 0, 0);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 0);
    cyc(0, 1, 8'h3C, 10'h245, 0, 0, 0);
    cyc(0, 1, 8'h3C, 10'h0FA, 1, 1, 0);
    cyc(0, 0, 8'h00, 10'h245, 0, 0, 0);
    cyc(1, 0, 8'h55, 10'h368, 1, 0, 0);
    cyc(1, 0, 8'h55, 10'h2A5, 0, 0, 0);
    cyc(1, 0, 8'hD5, 10'h2A6, 1, 0, 0);
    cyc(1, 0, 8'h01, 10'h1D4, 0, 0, 0);
    cyc(0, 0, 8'h00, 10'h2E8, 1, 0, 0);
    cyc(0, 0, 8'h00, 10'h3A8, 0, 0, 0);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 0);
    cyc(0, 0, 8'h00, 10'h245, 0, 0, 0);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 0);
    cyc(1, 0, 8'h55, 10'h245, 0, 0, 1);
    cyc(1, 0, 8'h55, 10'h368, 1, 0, 1);
    cyc(0, 0, 8'h00, 10'h2E8, 0, 0, 1);
    cyc(1, 0, 8'h99, 10'h3A8, 1, 0, 2);
    cyc(1, 0, 8'h99, 10'h3A8, 0, 0, 3);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 3);
    cyc(0, 0, 8'h00, 10'h245, 0, 0, 3);
    cyc(1, 0, 8'h55, 10'h368, 1, 0, 3);
    cyc(1, 0, 8'h00, 10'h274, 0, 0, 3);
    cyc(1, 0, 8'h20, 10'h279, 1, 1, 3);
    cyc(0, 0, 8'h00, 10'h117, 0, 1, 3);
    cyc(0, 0, 8'h00, 10'h057, 1, 1, 3);
    cyc(0, 0, 8'h00, 10'h057, 0, 1, 3);
    cyc(0, 0, 8'h00, 10'h305, 1, 0, 3);
    cyc(0, 0, 8'h00, 10'h296, 0, 0, 3);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 3);
    cyc(0, 0, 8'h00, 10'h245, 0, 0, 3);
    cyc(1, 0, 8'h55, 10'h368, 1, 0, 3);
    cyc(1, 0, 8'h55, 10'h2A5, 0, 0, 3);
    cyc(1, 1, 8'h55, ER_CG, 1, 0, 3);
    cyc(1, 0, 8'h01, 10'h1D4, 0, 0, 3);
    #3 mr_main_reset_n = 1'b0;
    #1;
    check("arst_code", tx_code_group, 10'h0FA);
    check("arst_even", tx_even, 1'b1);
    check("arst_rd", tx_rd_pos, 1'b1);
    check("arst_drop", dropped_octets, 0);
    TX_EN = 1'b0;
    #2 mr_main_reset_n = 1'b1;
    cyc(0, 1, 8'h00, 10'h245, 0, 0, 0);
    cyc(0, 0, 8'h00, 10'h0FA, 1, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, 8'hA5);
      drive(1, 0, 8'hA5);
      drive(0, 0, 8'h00);
      drive(1, 0, 8'hA5);
      drive(1, 0, 8'hA5);
      drive(0, 0, 8'h00);
      check("sat_drop", dropped_octets, 3 * k > 15 ? 15 : 3 * k);
      check("sat_code", tx_code_group, 10'h0FA);
      check("sat_even", tx_even, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
